stump_control: RTL and testbench

Control sequencer for the Stump processor datapath. It steps every instruction through FETCH, EXECUTE and (for loads and stores only) MEMORY. It decodes the instruction register into select and enable signals for the register bank, shifter, ALU and memory interface. It owns the 4-bit condition-code register {N,Z,V,C} and uses it to decide branches.

---
 rtl/stump_pkg.sv | 47 ++++
 rtl/stump_cond_eval.sv | 40 ++++
 rtl/stump_control.sv | 148 ++++++++++++++
 tb/tb_stump_control.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stump_pkg.sv
// rtl/stump_pkg.sv - shared encodings for the Stump control sequencer
package stump_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SBC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    localparam logic [3:0] COND_AL = 4'h0;
    localparam logic [3:0] COND_NV = 4'h1;
    localparam logic [3:0] COND_HI = 4'h2;
    localparam logic [3:0] COND_LS = 4'h3;
    localparam logic [3:0] COND_CC = 4'h4;
    localparam logic [3:0] COND_CS = 4'h5;
    localparam logic [3:0] COND_NE = 4'h6;
    localparam logic [3:0] COND_EQ = 4'h7;
    localparam logic [3:0] COND_VC = 4'h8;
    localparam logic [3:0] COND_VS = 4'h9;
    localparam logic [3:0] COND_PL = 4'hA;
    localparam logic [3:0] COND_MI = 4'hB;
    localparam logic [3:0] COND_GE = 4'hC;
    localparam logic [3:0] COND_LT = 4'hD;
    localparam logic [3:0] COND_GT = 4'hE;
    localparam logic [3:0] COND_LE = 4'hF;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_ASR  = 2'b01;
    localparam logic [1:0] SH_ROR  = 2'b10;
    localparam logic [1:0] SH_RRC  = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/stump_cond_eval.sv
// rtl/stump_cond_eval.sv - branch condition evaluator over {N,Z,V,C}
module stump_cond_eval
    import stump_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] cc_i,
    output logic       take_o
);

    logic n, z, v, c;

    assign n = cc_i[FLAG_N];
    assign z = cc_i[FLAG_Z];
    assign v = cc_i[FLAG_V];
    assign c = cc_i[FLAG_C];

    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            COND_AL: take_o = 1'b1;
            COND_NV: take_o = 1'b0;
            COND_HI: take_o = c & ~z;
            COND_LS: take_o = ~c | z;
            COND_CC: take_o = ~c;
            COND_CS: take_o = c;
            COND_NE: take_o = ~z;
            COND_EQ: take_o = z;
            COND_VC: take_o = ~v;
            COND_VS: take_o = v;
            COND_PL: take_o = ~n;
            COND_MI: take_o = n;
            COND_GE: take_o = n ~^ v;
            COND_LT: take_o = n ^ v;
            COND_GT: take_o = ~z & (n ~^ v);
            COND_LE: take_o = z | (n ^ v);
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// rtl/stump_control.sv - FETCH/EXECUTE/MEMORY sequencer and decoder for the Stump datapath
module stump_control
    import stump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  alu_flags,
    input  logic [15:0] alu_result,
    output logic [1:0]  state,
    output logic [3:0]  cc,
    output logic [15:0] addr,
    output logic        ir_en,
    output logic        pc_inc,
    output logic [2:0]  func,
    output logic [2:0]  src_a,
    output logic [2:0]  src_b,
    output logic [2:0]  dest,
    output logic        opb_imm,
    output logic        imm_br,
    output logic [1:0]  shift_op,
    output logic        reg_write,
    output logic        wb_mem,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic        addr_alu
);

    state_t      state_q, state_d;
    logic [3:0]  cc_q, cc_d;
    logic [15:0] addr_q, addr_d;

    logic [2:0] opc;
    logic       imm_type;
    logic       s_l;
    logic       take;
    logic       is_alu;

    assign opc      = ir[15:13];
    assign imm_type = ir[12];
    assign s_l      = ir[11];
    assign is_alu   = (opc != OP_LDST) && (opc != OP_BCC);

    stump_cond_eval u_cond (
        .cond_i (ir[11:8]),
        .cc_i   (cc_q),
        .take_o (take)
    );

    always_comb begin
        state_d = FETCH;
        cc_d    = cc_q;
        addr_d  = addr_q;
        case (state_q)
            FETCH:   state_d = EXECUTE;
            EXECUTE: begin
                if (opc == OP_LDST) begin
                    state_d = MEMORY;
                    addr_d  = alu_result;
                end else if (is_alu && s_l) begin
                    cc_d = alu_flags;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cc_q    <= 4'b0000;
            addr_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            addr_q  <= addr_d;
        end
    end

    // Strobes are forced low while rst is high so a reset landing mid-instruction
    // cannot corrupt memory or the register bank.
    logic ren_raw, wen_raw, rw_raw, ir_en_raw, pc_inc_raw;

    always_comb begin
        ir_en_raw  = 1'b0;
        pc_inc_raw = 1'b0;
        ren_raw    = 1'b0;
        wen_raw    = 1'b0;
        rw_raw     = 1'b0;
        func       = OP_ADD;
        src_a      = ir[7:5];
        src_b      = ir[4:2];
        dest       = ir[10:8];
        opb_imm    = 1'b0;
        imm_br     = 1'b0;
        shift_op   = SH_NONE;
        wb_mem     = 1'b0;
        addr_alu   = 1'b0;
        case (state_q)
            FETCH: begin
                ren_raw    = 1'b1;
                ir_en_raw  = 1'b1;
                pc_inc_raw = 1'b1;
            end
            EXECUTE: begin
                if (opc == OP_BCC) begin
                    src_a   = 3'd7;
                    dest    = 3'd7;
                    opb_imm = 1'b1;
                    imm_br  = 1'b1;
                    rw_raw  = take;
                end else begin
                    func     = is_alu ? opc : OP_ADD;
                    opb_imm  = imm_type;
                    shift_op = imm_type ? SH_NONE : ir[1:0];
                    rw_raw   = is_alu;
                end
            end
            MEMORY: begin
                addr_alu = 1'b1;
                if (s_l) begin
                    wen_raw = 1'b1;
                    src_a   = ir[10:8];
                end else begin
                    ren_raw = 1'b1;
                    wb_mem  = 1'b1;
                    rw_raw  = 1'b1;
                end
            end
            default: begin
                src_a = 3'd0;
                src_b = 3'd0;
                dest  = 3'd0;
            end
        endcase
    end

    assign ir_en     = ir_en_raw  & ~rst;
    assign pc_inc    = pc_inc_raw & ~rst;
    assign mem_ren   = ren_raw    & ~rst;
    assign mem_wen   = wen_raw    & ~rst;
    assign reg_write = rw_raw     & ~rst;

    assign state = state_q;
    assign cc    = cc_q;
    assign addr  = addr_q;

endmodule

// File: tb/tb_stump_control.sv
// tb/tb_stump_control.sv - scoreboard bench for stump_control
module tb_stump_control;
    import stump_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  alu_flags;
    logic [15:0] alu_result;
    logic [1:0]  state;
    logic [3:0]  cc;
    logic [15:0] addr;
    logic        ir_en, pc_inc, opb_imm, imm_br, reg_write, wb_mem;
    logic        mem_ren, mem_wen, addr_alu;
    logic [2:0]  func, src_a, src_b, dest;
    logic [1:0]  shift_op;

    always #5 clk = ~clk;

    stump_control dut (
        .clk(clk), .rst(rst), .ir(ir), .alu_flags(alu_flags), .alu_result(alu_result),
        .state(state), .cc(cc), .addr(addr), .ir_en(ir_en), .pc_inc(pc_inc),
        .func(func), .src_a(src_a), .src_b(src_b), .dest(dest), .opb_imm(opb_imm),
        .imm_br(imm_br), .shift_op(shift_op), .reg_write(reg_write), .wb_mem(wb_mem),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .addr_alu(addr_alu)
    );

    typedef enum int {
        SIG_STATE, SIG_CC, SIG_ADDR, SIG_IR_EN, SIG_PC_INC, SIG_FUNC, SIG_SRC_A,
        SIG_SRC_B, SIG_DEST, SIG_OPB_IMM, SIG_IMM_BR, SIG_SHIFT, SIG_REG_WRITE,
        SIG_WB_MEM, SIG_MEM_REN, SIG_MEM_WEN, SIG_ADDR_ALU
    } sig_t;

    typedef struct {
        sig_t        sel;
        logic [15:0] exp;
        int          step;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic logic [15:0] observe(sig_t s);
        case (s)
            SIG_STATE:     return {14'd0, state};
            SIG_CC:        return {12'd0, cc};
            SIG_ADDR:      return addr;
            SIG_IR_EN:     return {15'd0, ir_en};
            SIG_PC_INC:    return {15'd0, pc_inc};
            SIG_FUNC:      return {13'd0, func};
            SIG_SRC_A:     return {13'd0, src_a};
            SIG_SRC_B:     return {13'd0, src_b};
            SIG_DEST:      return {13'd0, dest};
            SIG_OPB_IMM:   return {15'd0, opb_imm};
            SIG_IMM_BR:    return {15'd0, imm_br};
            SIG_SHIFT:     return {14'd0, shift_op};
            SIG_REG_WRITE: return {15'd0, reg_write};
            SIG_WB_MEM:    return {15'd0, wb_mem};
            SIG_MEM_REN:   return {15'd0, mem_ren};
            SIG_MEM_WEN:   return {15'd0, mem_wen};
            SIG_ADDR_ALU:  return {15'd0, addr_alu};
            default:       return 16'hxxxx;
        endcase
    endfunction

    task automatic ex(input sig_t s, input logic [15:0] v);
        exp_t e;
        e.sel  = s;
        e.exp  = v;
        e.step = step_no;
        q.push_back(e);
    endtask

    // Compare every expectation queued for this cycle mid-period, then advance one clock.
    task automatic tick();
        exp_t        e;
        logic [15:0] o;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL step%0d %s: observed %0h expected %0h", e.step, e.sel.name(), o, e.exp);
            end
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    task automatic drive(input logic r, input logic [15:0] i, input logic [3:0] f,
                         input logic [15:0] a);
        rst        = r;
        ir         = i;
        alu_flags  = f;
        alu_result = a;
    endtask

    task automatic fetch(input logic [15:0] i, input logic [3:0] f, input logic [15:0] a,
                         input logic [3:0] exp_cc);
        drive(1'b0, i, f, a);
        ex(SIG_STATE, 16'd0);
        ex(SIG_CC, {12'd0, exp_cc});
        ex(SIG_IR_EN, 16'd1);
        ex(SIG_PC_INC, 16'd1);
        ex(SIG_MEM_REN, 16'd1);
        ex(SIG_ADDR_ALU, 16'd0);
        ex(SIG_REG_WRITE, 16'd0);
        ex(SIG_FUNC, 16'd0);
        tick();
    endtask

    task automatic branch(input logic [15:0] i, input logic [3:0] exp_cc, input logic take);
        fetch(i, 4'b1111, 16'h0, exp_cc);
        ex(SIG_STATE, 16'd1);
        ex(SIG_REG_WRITE, {15'd0, take});
        ex(SIG_DEST, 16'd7);
        ex(SIG_SRC_A, 16'd7);
        ex(SIG_IMM_BR, 16'd1);
        ex(SIG_OPB_IMM, 16'd1);
        ex(SIG_FUNC, 16'd0);
        ex(SIG_MEM_WEN, 16'd0);
        tick();
    endtask

    initial begin
        drive(1'b1, 16'h0000, 4'b0000, 16'h0000);
        @(posedge clk);
        #1;

        // ADDS sets cc to 1111 so the later reset visibly clears it
        fetch(16'h094C, 4'b1111, 16'h0, 4'b0000);
        ex(SIG_STATE, 16'd1);
        ex(SIG_REG_WRITE, 16'd1);
        tick();
        fetch(16'h094C, 4'b0101, 16'h0, 4'b1111);

        // reset held two cycles starting in EXECUTE
        drive(1'b1, 16'h094C, 4'b0101, 16'h0);
        ex(SIG_STATE, 16'd1);
        ex(SIG_REG_WRITE, 16'd0);
        ex(SIG_MEM_WEN, 16'd0);
        ex(SIG_MEM_REN, 16'd0);
        tick();
        ex(SIG_STATE, 16'd0);
        ex(SIG_CC, 16'd0);
        ex(SIG_REG_WRITE, 16'd0);
        ex(SIG_MEM_WEN, 16'd0);
        ex(SIG_MEM_REN, 16'd0);
        ex(SIG_IR_EN, 16'd0);
        tick();

        // ADDS R1,R2,R3 with flags 0101
        fetch(16'h094C, 4'b0101, 16'h0, 4'b0000);
        ex(SIG_STATE, 16'd1);
        ex(SIG_FUNC, 16'd0);
        ex(SIG_REG_WRITE, 16'd1);
        ex(SIG_DEST, 16'd1);
        ex(SIG_SRC_A, 16'd2);
        ex(SIG_SRC_B, 16'd3);
        ex(SIG_OPB_IMM, 16'd0);
        ex(SIG_IR_EN, 16'd0);
        tick();

        // AND R2,R3,R4 ASR, no S
        fetch(16'h8271, 4'b1111, 16'h0, 4'b0101);
        ex(SIG_FUNC, 16'd4);
        ex(SIG_SHIFT, 16'd1);
        ex(SIG_REG_WRITE, 16'd1);
        ex(SIG_DEST, 16'd2);
        tick();

        // SUBS R3,R1,#5: immediate forces shift_op to 00
        fetch(16'h5B25, 4'b0100, 16'h0, 4'b0101);
        ex(SIG_FUNC, 16'd2);
        ex(SIG_OPB_IMM, 16'd1);
        ex(SIG_SHIFT, 16'd0);
        ex(SIG_IMM_BR, 16'd0);
        ex(SIG_REG_WRITE, 16'd1);
        tick();

        branch(16'hE710, 4'b0100, 1'b1);
        branch(16'hE610, 4'b0100, 1'b0);
        branch(16'hE110, 4'b0100, 1'b0);
        branch(16'hE010, 4'b0100, 1'b1);

        // LD R4,[R5,#3]
        fetch(16'hD4A3, 4'b1111, 16'h0043, 4'b0100);
        ex(SIG_STATE, 16'd1);
        ex(SIG_FUNC, 16'd0);
        ex(SIG_OPB_IMM, 16'd1);
        ex(SIG_REG_WRITE, 16'd0);
        ex(SIG_MEM_REN, 16'd0);
        tick();
        ex(SIG_STATE, 16'd2);
        ex(SIG_ADDR, 16'h0043);
        ex(SIG_ADDR_ALU, 16'd1);
        ex(SIG_MEM_REN, 16'd1);
        ex(SIG_MEM_WEN, 16'd0);
        ex(SIG_WB_MEM, 16'd1);
        ex(SIG_REG_WRITE, 16'd1);
        ex(SIG_DEST, 16'd4);
        tick();

        // ST R4,[R5,#3]: ir[11]=1 with flags 1111 must not touch cc
        fetch(16'hDCA3, 4'b1111, 16'h1234, 4'b0100);
        ex(SIG_STATE, 16'd1);
        ex(SIG_REG_WRITE, 16'd0);
        tick();
        ex(SIG_STATE, 16'd2);
        ex(SIG_ADDR, 16'h1234);
        ex(SIG_ADDR_ALU, 16'd1);
        ex(SIG_MEM_WEN, 16'd1);
        ex(SIG_MEM_REN, 16'd0);
        ex(SIG_REG_WRITE, 16'd0);
        ex(SIG_WB_MEM, 16'd0);
        ex(SIG_SRC_A, 16'd4);
        tick();

        // ADDS R0,R0,#0 with flags N=1
        fetch(16'h1800, 4'b1000, 16'h0, 4'b0100);
        ex(SIG_REG_WRITE, 16'd1);
        ex(SIG_OPB_IMM, 16'd1);
        tick();

        branch(16'hED10, 4'b1000, 1'b1);
        branch(16'hEC10, 4'b1000, 1'b0);
        branch(16'hEE10, 4'b1000, 1'b0);
        branch(16'hEF10, 4'b1000, 1'b1);

        fetch(16'h0000, 4'b0000, 16'h0, 4'b1000);
        ex(SIG_ADDR, 16'h1234);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
